// File: rtl/ifetch_pkg.sv
// Shared widths, the IF/ID entry type and a PC alignment helper for the fetch stage.
// Latency: none (types and constants only). Backpressure: n/a.
package ifetch_pkg;

    localparam int PC_SIZE    = 32;
    localparam int INSTR_SIZE = 32;
    localparam int XLEN       = 32;

    localparam logic [INSTR_SIZE-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PC_SIZE-1:0]    pc;
        logic [INSTR_SIZE-1:0] instr;
    } fetch_t;

    function automatic logic [PC_SIZE-1:0] word_align(input logic [PC_SIZE-1:0] addr);
        return addr & ~PC_SIZE'(3);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response bus: fetch stage is master, memory is slave.
// Latency: none. Backpressure: request held until imem_req_ready; response is never stalled.
interface ifetch_if;
    import ifetch_pkg::*;

    logic                  imem_req_valid;
    logic [PC_SIZE-1:0]    imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [INSTR_SIZE-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/ifetch_if_id_reg.sv
// IF/ID pipeline register plus one-entry skid buffer; 1-cycle load from memory or skid.
// Backpressure: holds while consume is low; flush clears valid regardless of consume.
module ifetch_if_id_reg
    import ifetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_mem,
    input  fetch_t                mem_entry,
    input  logic                  skid_wr,
    input  logic                  load_skid,
    input  logic                  flush,
    input  logic                  consume,
    output logic                  valid,
    output logic [PC_SIZE-1:0]    pc,
    output logic [INSTR_SIZE-1:0] instr
);

    fetch_t skid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid        <= 1'b0;
            pc           <= '0;
            instr        <= INSTR_NOP;
            skid_q.pc    <= '0;
            skid_q.instr <= INSTR_NOP;
        end else begin
            if (skid_wr) begin
                skid_q <= mem_entry;
            end
            if (flush) begin
                valid <= 1'b0;
            end else if (load_mem) begin
                valid <= 1'b1;
                pc    <= mem_entry.pc;
                instr <= mem_entry.instr;
            end else if (load_skid) begin
                valid <= 1'b1;
                pc    <= skid_q.pc;
                instr <= skid_q.instr;
            end else if (consume) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ifetch.sv
// RV32I fetch: PC generation, single-outstanding imem requests, IF/ID write; 2 cycles/instr best case.
// Backpressure: request held while imem not ready; id_stall parks a response in the skid (no new request).
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [PC_SIZE-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    ifetch_if.master              mem,
    input  logic                  id_stall,
    input  logic                  bxx_flush,
    input  logic [PC_SIZE-1:0]    bxx_target,
    input  logic                  jalr_en,
    input  logic [XLEN-1:0]       jalr_reg,
    input  logic [XLEN-1:0]       jalr_imm,
    output logic                  id_valid,
    output logic [PC_SIZE-1:0]    id_pc,
    output logic [INSTR_SIZE-1:0] id_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               req_valid_q;
    logic [PC_SIZE-1:0] pc_q;
    logic [PC_SIZE-1:0] fetch_pc_q;
    logic               kill_q;

    logic               accept;
    logic               rsp_in;
    logic               jalr_take;
    logic               redirect;
    logic [XLEN-1:0]    jalr_sum;
    logic [PC_SIZE-1:0] target;
    logic               if_free;
    logic               rsp_keep;
    logic               load_mem;
    logic               skid_wr;
    logic               load_skid;
    fetch_t             mem_entry;

    assign mem.imem_req_valid = req_valid_q;
    assign mem.imem_req_addr  = pc_q;

    assign mem_entry.pc    = fetch_pc_q;
    assign mem_entry.instr = mem.imem_rsp_data;

    always_comb begin
        accept    = req_valid_q && mem.imem_req_ready;
        // Responses outside S_WAIT are protocol violations and are dropped here.
        rsp_in    = (state_q == S_WAIT) && mem.imem_rsp_valid;
        // The branch in EX is older than the jalr in ID, so it wins.
        jalr_take = jalr_en && id_valid && !id_stall && !bxx_flush;
        redirect  = bxx_flush || jalr_take;
        jalr_sum  = jalr_reg + jalr_imm;
        target    = bxx_flush ? word_align(bxx_target) : word_align(jalr_sum);
        if_free   = !id_valid || !id_stall;
        rsp_keep  = rsp_in && !kill_q && !redirect;
        load_mem  = rsp_keep && if_free;
        skid_wr   = rsp_keep && !if_free;
        load_skid = (state_q == S_HOLD) && !id_stall && !redirect;

        state_d = state_q;
        case (state_q)
            S_REQ:   if (accept) state_d = S_WAIT;
            S_WAIT:  if (rsp_in) state_d = skid_wr ? S_HOLD : S_REQ;
            S_HOLD:  if (redirect || !id_stall) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b0;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= (state_d == S_REQ);

            if (redirect) begin
                pc_q <= target;
            end else if (accept) begin
                pc_q <= pc_q + PC_SIZE'(4);
            end

            if (accept) begin
                fetch_pc_q <= pc_q;
            end

            // kill_q marks an accepted request whose response belongs to the old path.
            case (state_q)
                S_REQ: begin
                    if (accept) kill_q <= redirect;
                end
                S_WAIT: begin
                    if (rsp_in) begin
                        kill_q <= 1'b0;
                    end else if (redirect) begin
                        kill_q <= 1'b1;
                    end
                end
                default: begin
                    kill_q <= kill_q;
                end
            endcase
        end
    end

    ifetch_if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_mem  (load_mem),
        .mem_entry (mem_entry),
        .skid_wr   (skid_wr),
        .load_skid (load_skid),
        .flush     (bxx_flush),
        .consume   (!id_stall),
        .valid     (id_valid),
        .pc        (id_pc),
        .instr     (id_instr)
    );

endmodule
